// File: rtl/rom_boot_loader_if.sv
// Bus bundles for the boot loader: the incoming byte stream (valid/ready) and
// the ROM write port it drives.

interface byte_stream_if;
    logic       valid;
    logic [7:0] data;
    logic       ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

interface rom_wr_if;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;

    modport master (output ce, output we, output addr, output data);
    modport slave  (input ce, input we, input addr, input data);
endinterface

// File: rtl/rom_boot_loader.sv
// Byte-stream boot loader: takes a framed stream (word count, then words, all LSB first)
// and writes the words into the instruction ROM. Define ROM_LOAD_CHKSUM_EN for an XOR trailer byte.

module rom_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic         i_Clk,
    input  logic         i_Rst_n,
    input  logic         i_start,
    byte_stream_if.slave rx,
    rom_wr_if.master     rom,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
`ifdef ROM_LOAD_CHKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

    state_t      state, state_next;
    logic [1:0]  byte_cnt;
    logic [31:0] shift_q;
    logic [31:0] word_total;
    logic [31:0] word_idx;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [7:0]  chk_q;
    logic        done_q, err_q;

    logic        ready, busy, we;
    logic        xfer, last_byte;
    logic [31:0] assembled;

    assign xfer      = rx.valid & ready;
    assign last_byte = (byte_cnt == 2'd3);
    assign assembled = {rx.data, shift_q[31:8]};

    // NOTE: sequential state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        we         = 1'b0;
        case (state)
            S_IDLE: if (i_start) state_next = S_LEN;
            S_LEN: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (xfer && last_byte) begin
                    if (assembled == 32'd0)
`ifdef ROM_LOAD_CHKSUM_EN
                        state_next = S_CHK;
`else
                        state_next = S_DONE;
`endif
                    else if (assembled > 32'(MAX_WORDS))
                        state_next = S_DONE;
                    else
                        state_next = S_DATA;
                end
            end
            S_DATA: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (xfer && last_byte) state_next = S_WRITE;
            end
            S_WRITE: begin
                busy = 1'b1;
                we   = 1'b1;
                // word_total never exceeds MAX_WORDS here, so word_idx + 1 cannot wrap.
                if (word_idx + 32'd1 < word_total) state_next = S_DATA;
`ifdef ROM_LOAD_CHKSUM_EN
                else                               state_next = S_CHK;
`else
                else                               state_next = S_DONE;
`endif
            end
`ifdef ROM_LOAD_CHKSUM_EN
            S_CHK: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (xfer) state_next = S_DONE;
            end
`endif
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            byte_cnt   <= 2'd0;
            shift_q    <= 32'd0;
            word_total <= 32'd0;
            word_idx   <= 32'd0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            chk_q      <= 8'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (state == S_IDLE && i_start) begin
                done_q   <= 1'b0;
                err_q    <= 1'b0;
                word_idx <= 32'd0;
                byte_cnt <= 2'd0;
                chk_q    <= 8'd0;
            end
            if (xfer) begin
                shift_q  <= assembled;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state == S_LEN && xfer && last_byte) begin
                word_total <= assembled;
                if (assembled > 32'(MAX_WORDS)) err_q <= 1'b1;
            end
            if (state == S_DATA && xfer) begin
                chk_q <= chk_q ^ rx.data;
                if (last_byte) begin
                    addr_q <= BASE_ADDR + {word_idx[29:0], 2'b00};
                    data_q <= assembled;
                end
            end
            if (state == S_WRITE) word_idx <= word_idx + 32'd1;
`ifdef ROM_LOAD_CHKSUM_EN
            if (state == S_CHK && xfer && rx.data != chk_q) err_q <= 1'b1;
`endif
            if (state_next == S_DONE) done_q <= 1'b1;
        end
    end

    assign rx.ready = ready;
    assign rom.ce   = busy;
    assign rom.we   = we;
    assign rom.addr = addr_q;
    assign rom.data = data_q;
    assign o_busy   = busy;
    assign o_done   = done_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_rom_boot_loader.sv
// Scoreboard bench for rom_boot_loader: loads are modelled as lists of expected ROM
// writes plus an expected error flag; a monitor pops and compares on every write strobe.

module tb_rom_boot_loader;
    localparam int          MAX_WORDS = 1024;
    localparam logic [31:0] BASE      = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, err;

    byte_stream_if rx ();
    rom_wr_if      rom ();

    rom_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAX_WORDS)) dut (
        .i_Clk  (clk),
        .i_Rst_n(rst_n),
        .i_start(start),
        .rx     (rx),
        .rom    (rom),
        .o_busy (busy),
        .o_done (done),
        .o_err  (err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    wr_t         exp_q[$];
    logic [31:0] payload[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (rst_n && rom.we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", rom.addr, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", rom.addr, e.addr);
                check("write_data", rom.data, e.data);
                check("write_ce", {31'd0, rom.ce}, 32'd1);
            end
        end
    end

    function automatic logic [7:0] payload_xor(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < n; i++)
            x = x ^ payload[i][7:0] ^ payload[i][15:8] ^ payload[i][23:16] ^ payload[i][31:24];
        return x;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waitc = 0;
        @(negedge clk);
        rx.valid = 1'b1;
        rx.data  = b;
        while (!rx.ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!rx.ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            rx.valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 rx.valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One complete load: model the expected writes and flags, drive the frame, check the end.
    task automatic run_load(input logic [31:0] n_claim, input logic [7:0] trailer,
                            input int gap, input bit mid_start);
        bit oversize;
        bit exp_err;
        int c;
        oversize = (n_claim > MAX_WORDS);
        exp_err  = oversize;
        if (!oversize) begin
            for (int i = 0; i < int'(n_claim); i++) begin
                wr_t w;
                w.addr = BASE + 32'(4 * i);
                w.data = payload[i];
                exp_q.push_back(w);
            end
`ifdef ROM_LOAD_CHKSUM_EN
            if (trailer != payload_xor(int'(n_claim))) exp_err = 1'b1;
`endif
        end
        pulse_start();
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_clears_done", {31'd0, done}, 32'd0);
        check("start_clears_err", {31'd0, err}, 32'd0);
        send_word(n_claim, gap);
        if (!oversize) begin
            for (int i = 0; i < int'(n_claim); i++) begin
                if (mid_start && i == 0) begin
                    send_byte(payload[i][7:0], gap);
                    send_byte(payload[i][15:8], gap);
                    pulse_start();
                    send_byte(payload[i][23:16], gap);
                    send_byte(payload[i][31:24], gap);
                end else begin
                    send_word(payload[i], gap);
                end
            end
`ifdef ROM_LOAD_CHKSUM_EN
            send_byte(trailer, 0);
`endif
        end
        c = 0;
        while (!done && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("done_latency_ok", {31'd0, (c <= 2) || gap > 0}, 32'd1);
        check("err_flag", {31'd0, err}, {31'd0, exp_err});
        check("busy_after", {31'd0, busy}, 32'd0);
        check("ce_after", {31'd0, rom.ce}, 32'd0);
        check("writes_outstanding", exp_q.size(), 32'd0);
        exp_q.delete();
        @(negedge clk);
        check("done_sticky", {31'd0, done}, 32'd1);
    endtask

    task automatic set_test1();
        payload.delete();
        payload.push_back(32'h0000_0013);
        payload.push_back(32'h0040_0093);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rx.valid = 1'b0;
        rx.data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_ready", {31'd0, rx.ready}, 32'd0);
        check("rst_we", {31'd0, rom.we}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", {31'd0, rx.ready}, 32'd0);

        // Directed: two words, empty frame, oversize count.
        set_test1();
        run_load(32'd2, 8'hC0, 0, 1'b0);
        run_load(32'd0, 8'h00, 0, 1'b0);
        run_load(32'd1025, 8'h00, 0, 1'b0);

        // Reset between bytes 2 and 3 of the first word.
        set_test1();
        pulse_start();
        send_word(32'd2, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
        check("midrst_we", {31'd0, rom.we}, 32'd0);
        check("midrst_ce", {31'd0, rom.ce}, 32'd0);
        check("midrst_ready", {31'd0, rx.ready}, 32'd0);
        check("midrst_addr", rom.addr, 32'd0);
        check("midrst_data", rom.data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_load(32'd2, 8'hC0, 0, 1'b0);

        // Valid toggling every cycle plus a re-pulsed start mid-load.
        run_load(32'd2, 8'hC0, 1, 1'b1);

`ifdef ROM_LOAD_CHKSUM_EN
        run_load(32'd2, 8'h00, 0, 1'b0);
`endif

        // Randomised loads with random gaps and (when enabled) random trailer corruption.
        for (int t = 0; t < 8; t++) begin
            int n;
            logic [7:0] tr;
            n = $urandom_range(1, 8);
            payload.delete();
            for (int i = 0; i < n; i++) payload.push_back($urandom);
            tr = payload_xor(n);
            if ($urandom_range(0, 2) == 0) tr = tr ^ 8'($urandom_range(1, 255));
            run_load(32'(n), tr, $urandom_range(0, 2), 1'b0);
        end

        // Boundary: exactly MAX_WORDS is accepted.
        payload.delete();
        for (int i = 0; i < MAX_WORDS; i++) payload.push_back($urandom);
        run_load(32'(MAX_WORDS), payload_xor(MAX_WORDS), 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
